dlatch_1: RTL and testbench

DLATCH_1 -- requirements
Module: dlatch_1

---
 rtl/dlatch_1.sv | 28 ++
 tb/tb_dlatch_1.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dlatch_1.sv
// Parameterised transparent-high D latch with asynchronous active-low clear/preset.
// qn is the bitwise complement of q at all times, including during reset.
module dlatch_1 #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             e,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] q_q;

    // Reset outranks the gate; releasing reset while e is high lets d through at once.
    always_latch begin
        if (!reset) begin
            q_q <= RESET_VAL;
        end else if (e) begin
            q_q <= d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_dlatch_1.sv
// Self-checking bench for dlatch_1: directed scenarios plus randomized single-change
// stimulus checked against a rule-based latch model, on 1-, 4- and 8-bit instances.
module tb_dlatch_1;

    logic       e;
    logic       reset;
    logic       d1;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       q1, qn1;
    logic [3:0] q4, qn4;
    logic [7:0] q8, qn8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [3:0] RV4 = 4'hA;
    localparam logic [7:0] RV8 = 8'h3C;

    dlatch_1 u_dut1 (
        .e(e), .reset(reset), .d(d1), .q(q1), .qn(qn1)
    );

    dlatch_1 #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (
        .e(e), .reset(reset), .d(d4), .q(q4), .qn(qn4)
    );

    dlatch_1 #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
        .e(e), .reset(reset), .d(d8), .q(q8), .qn(qn8)
    );

    task automatic test_reset();
        reset = 1'b0; e = 1'b0; d1 = 1'b0; d4 = 4'h0; d8 = 8'h00;
        #1;
        n_checks++;
        if ({q1, qn1} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_w1: q/qn=%b%b expected 01", q1, qn1);
        end
        n_checks++;
        if ({q4, qn4} !== {RV4, ~RV4}) begin
            n_fail++;
            $display("FAIL reset_w4: q=%h qn=%h expected q=%h qn=%h", q4, qn4, RV4, ~RV4);
        end
        n_checks++;
        if ({q8, qn8} !== {RV8, ~RV8}) begin
            n_fail++;
            $display("FAIL reset_w8: q=%h qn=%h expected q=%h qn=%h", q8, qn8, RV8, ~RV8);
        end
        // Gate and data activity under reset must not disturb q.
        e = 1'b1; d1 = 1'b1; d4 = 4'h5; d8 = 8'hFF;
        #1;
        n_checks++;
        if ({q1, q4, q8} !== {1'b0, RV4, RV8}) begin
            n_fail++;
            $display("FAIL reset_gate_ignored: q1=%b q4=%h q8=%h expected 0 %h %h", q1, q4, q8, RV4, RV8);
        end
        e = 1'b0; d1 = 1'b0; d4 = 4'h0; d8 = 8'h00;
        #8;
    endtask

    task automatic test_transparent();
        // t=10: release with e low keeps reset value
        reset = 1'b1;
        #1;
        n_checks++;
        if ({q1, qn1, q4, q8} !== {2'b01, RV4, RV8}) begin
            n_fail++;
            $display("FAIL release_hold: q1=%b qn1=%b q4=%h q8=%h expected 0 1 %h %h", q1, qn1, q4, q8, RV4, RV8);
        end
        #4;                      // t=15
        e = 1'b1;
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL transp_d0: q=%b expected 0", q1);
        end
        #3;                      // t=19
        d1 = 1'b1;
        #1;
        n_checks++;
        if ({q1, qn1} !== 2'b10) begin
            n_fail++;
            $display("FAIL transp_d1: q/qn=%b%b expected 10", q1, qn1);
        end
        #9;                      // t=29
        d1 = 1'b0;
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL transp_d0b: q=%b expected 0", q1);
        end
        #4;                      // t=34
        d1 = 1'b1;
        #1;
        $display("monitor: en=%b d=%b q=%b", e, d1, q1);
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL transp_d1b: q=%b expected 1", q1);
        end
    endtask

    task automatic test_hold();
        e = 1'b1; d1 = 1'b1; d4 = 4'h9;
        #2;
        e = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            d1 = ~d1;
            d4 = d4 ^ 4'hF;
            #2;
            n_checks++;
            if ({q1, qn1, q4} !== {2'b10, 4'h9}) begin
                n_fail++;
                $display("FAIL hold_%0d: q1=%b qn1=%b q4=%h expected 1 0 9", i, q1, qn1, q4);
            end
        end
    endtask

    task automatic test_reset_mid();
        e = 1'b1; d1 = 1'b1; d4 = 4'h3;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({q1, qn1, q4} !== {2'b01, RV4}) begin
            n_fail++;
            $display("FAIL reset_mid_transp: q1=%b qn1=%b q4=%h expected 0 1 %h", q1, qn1, q4, RV4);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({q1, q4} !== {1'b1, 4'h3}) begin
            n_fail++;
            $display("FAIL release_transp: q1=%b q4=%h expected 1 3", q1, q4);
        end
        // Reset while holding, then release with e low: reset value persists until e rises.
        e = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        d1 = 1'b1; d4 = 4'h7;
        #1;
        n_checks++;
        if ({q1, q4} !== {1'b0, RV4}) begin
            n_fail++;
            $display("FAIL reset_mid_hold: q1=%b q4=%h expected 0 %h", q1, q4, RV4);
        end
        e = 1'b1;
        #1;
        n_checks++;
        if ({q1, q4} !== {1'b1, 4'h7}) begin
            n_fail++;
            $display("FAIL gate_after_release: q1=%b q4=%h expected 1 7", q1, q4);
        end
    endtask

    task automatic test_wide();
        reset = 1'b0; e = 1'b0;
        #1;
        n_checks++;
        if (q4 !== 4'hA) begin
            n_fail++;
            $display("FAIL wide_reset: q=%h expected a", q4);
        end
        reset = 1'b1;
        #1;
        e = 1'b1; d4 = 4'h5;
        #1;
        n_checks++;
        if ({q4, qn4} !== {4'h5, 4'hA}) begin
            n_fail++;
            $display("FAIL wide_follow: q=%h qn=%h expected q=5 qn=a", q4, qn4);
        end
    endtask

    task automatic test_random();
        logic       x1;
        logic [3:0] x4;
        logic [7:0] x8;
        int unsigned pick;
        reset = 1'b0; e = 1'b0;
        #1;
        x1 = 1'b0; x4 = RV4; x8 = RV8;
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 9);
            // One input changes per step so a falling gate sees a stable d.
            if (pick == 0) begin
                reset = ~reset;
            end else if (pick <= 3) begin
                e = ~e;
            end else begin
                d1 = 1'($urandom);
                d4 = 4'($urandom);
                d8 = 8'($urandom);
            end
            if (!reset) begin
                x1 = 1'b0; x4 = RV4; x8 = RV8;
            end else if (e) begin
                x1 = d1; x4 = d4; x8 = d8;
            end
            #2;
            n_checks++;
            if ({q1, qn1, q4, qn4, q8, qn8} !== {x1, ~x1, x4, ~x4, x8, ~x8}) begin
                n_fail++;
                $display("FAIL rand_%0d: q1=%b qn1=%b q4=%h qn4=%h q8=%h qn8=%h expected %b %b %h %h %h %h (e=%b rst=%b)",
                         i, q1, qn1, q4, qn4, q8, qn8, x1, ~x1, x4, ~x4, x8, ~x8, e, reset);
            end
        end
    endtask

    initial begin
        test_reset();
        test_transparent();
        test_hold();
        test_reset_mid();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
